sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2: number of requester ports (1..8).
REQ-002 SHALL have parameter ADDR_W, default 20: SRAM word address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width (multiple of 8); BE_W = DATA_W/8.
REQ-004 SHALL have parameter WAIT_CYCLES, default 2: SRAM access strobe length in cycles (>=1).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port req  input  NUM_PORTS  per-port access request, held until ack.
REQ-008 SHALL have port we  input  NUM_PORTS  per-port write (1) / read (0).
REQ-009 SHALL have port addr  input  NUM_PORTS*ADDR_W  packed per-port address, port i at [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port wdata  input  NUM_PORTS*DATA_W  packed per-port write data.
REQ-011 SHALL have port be  input  NUM_PORTS*BE_W  packed per-port byte enables, active-high.
REQ-012 SHALL have port ack  output  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-013 SHALL have port rdata  output  DATA_W  read data, valid in ack cycle.
REQ-014 SHALL have ports sram_addr out ADDR_W; sram_be_n out BE_W; sram_ce_n, sram_oe_n, sram_we_n out 1; sram_dout out DATA_W; sram_dout_en out 1; sram_din in DATA_W (tristate resolved at top level).

Function
REQ-015 SHALL implement FSM states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
REQ-016 SHALL, in IDLE with any req high, select one winner, register its we/addr/wdata/be and port index on that edge, go to RD (we=0) or WR_SETUP (we=1).
REQ-017 SHALL, in RD, drive ce_n=0, oe_n=0 for exactly WAIT_CYCLES cycles (counter), capture sram_din into rdata on the last RD edge, then enter ACK.
REQ-018 SHALL, for writes, drive ce_n=0, dout_en=1, we_n=1 for one WR_SETUP cycle, we_n=0 for WAIT_CYCLES WR_PULSE cycles, we_n=1 for one WR_HOLD cycle with data still driven, then ACK.
REQ-019 SHALL assert ack[winner] for exactly the single ACK cycle, then return to IDLE.
REQ-020 SHALL give read latency: req sampled at edge k -> ack high in cycle k+WAIT_CYCLES+1; write: k+WAIT_CYCLES+3.
REQ-021 SHALL drive sram_be_n = ~be of winner during access; all ones, ce_n/oe_n/we_n = 1, dout_en = 0 in IDLE and ACK.
REQ-022 SHALL sample req only in IDLE; a req still high in the cycle after ack starts a new transaction (back-to-back allowed).
REQ-023 SHALL complete an in-flight transaction and issue ack even if the requester drops req mid-access.
REQ-024 SHALL hold rdata stable from ACK until the next read capture; writes leave rdata unchanged.
REQ-025 SHALL perform full strobe timing for a write with be all zero (no bytes modified, ack still issued).

Reset
REQ-026 SHALL, on rst low (any time, incl. mid-access), immediately force IDLE, ack=0, rdata=0, ce_n=oe_n=we_n=1, be_n all ones, dout_en=0, counter=0, priority pointer=0.

Configuration
REQ-027 SHALL, with ROUND_ROBIN_EN defined, arbitrate round-robin: search starts at port (last winner+1) mod NUM_PORTS, pointer updated on each grant.
REQ-028 SHALL, without ROUND_ROBIN_EN, arbitrate fixed priority: lowest-index requesting port wins (port 0 = data port, highest).

Structure
REQ-029 SHALL place FSM state enum and state encodings in shared package sram_arb_pkg.
REQ-030 SHALL implement winner selection in one sub-module sram_arb_pick (req, pointer -> one-hot grant, index, valid).

Verification
REQ-031 SHALL cover: single read, port 1, addr 0x00010, WAIT_CYCLES=2, sram_din=0xDEADBEEF -> oe_n low cycles k+1..k+2, ack[1] at k+3, rdata=0xDEADBEEF.
REQ-032 SHALL cover: write port 0, addr 0x00020, wdata 0x12345678, be 4'b0011 -> be_n 4'b1100, we_n low exactly 2 cycles, ack[0] at k+5.
REQ-033 SHALL cover: req=2'b11 held continuously, fixed priority -> port 0 served every transaction; with ROUND_ROBIN_EN -> acks alternate 0,1,0,1.
REQ-034 SHALL cover: rst low during WR_PULSE -> same cycle we_n=1, dout_en=0, ack=0; after release, pending req restarts from IDLE.
REQ-035 SHALL cover: req[1] dropped during RD -> ack[1] still pulses once; no second transaction issued.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM arbiter: access FSM encoding and an index-width helper.
package sram_arb_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WR_SETUP = 3'd2,
      WR_PULSE = 3'd3,
      WR_HOLD  = 3'd4,
      ACK      = 3'd5
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection: scans requesters starting at ptr and returns the first one found.
module sram_arb_pick
   import sram_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = 1
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] grant,
   output logic [IDX_W-1:0]     idx,
   output logic                 valid
);

   int               p;
   logic [IDX_W-1:0] pi;

   // ptr == 0 degenerates to fixed lowest-index priority
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      p     = 0;
      pi    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         p = int'(ptr) + i;
         if (p >= NUM_PORTS) p = p - NUM_PORTS;
         pi = IDX_W'(p);
         if (!valid && req[pi]) begin
            valid     = 1'b1;
            idx       = pi;
            grant[pi] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-port asynchronous SRAM arbiter with strobe timing FSM.
// Define ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0 highest).
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req,
   input  logic [NUM_PORTS-1:0]            we,
   input  logic [NUM_PORTS*ADDR_W-1:0]     addr,
   input  logic [NUM_PORTS*DATA_W-1:0]     wdata,
   input  logic [NUM_PORTS*(DATA_W/8)-1:0] be,
   output logic [NUM_PORTS-1:0]            ack,
   output logic [DATA_W-1:0]               rdata,
   output logic [ADDR_W-1:0]               sram_addr,
   output logic [DATA_W/8-1:0]             sram_be_n,
   output logic                            sram_ce_n,
   output logic                            sram_oe_n,
   output logic                            sram_we_n,
   output logic [DATA_W-1:0]               sram_dout,
   output logic                            sram_dout_en,
   input  logic [DATA_W-1:0]               sram_din
);

   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = idx_w(NUM_PORTS);
   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   state_t               state, next_state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     ptr, win_idx;
   logic [NUM_PORTS-1:0] grant, gnt_q;
   logic                 win_valid, last_beat;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [BE_W-1:0]      be_q;

   sram_arb_pick #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win_idx),
      .valid (win_valid)
   );

   assign last_beat = (cnt == CNT_W'(WAIT_CYCLES - 1));
   assign sram_addr = addr_q;
   assign sram_dout = wdata_q;

   always_comb begin
      next_state   = state;
      ack          = '0;
      sram_ce_n    = 1'b1;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_be_n    = '1;
      sram_dout_en = 1'b0;
      case (state)
         IDLE: if (win_valid) next_state = we[win_idx] ? WR_SETUP : RD;
         RD: begin
            sram_ce_n = 1'b0;
            sram_oe_n = 1'b0;
            sram_be_n = ~be_q;
            if (last_beat) next_state = ACK;
         end
         WR_SETUP: begin
            sram_ce_n    = 1'b0;
            sram_be_n    = ~be_q;
            sram_dout_en = 1'b1;
            next_state   = WR_PULSE;
         end
         WR_PULSE: begin
            sram_ce_n    = 1'b0;
            sram_we_n    = 1'b0;
            sram_be_n    = ~be_q;
            sram_dout_en = 1'b1;
            if (last_beat) next_state = WR_HOLD;
         end
         WR_HOLD: begin
            sram_ce_n    = 1'b0;
            sram_be_n    = ~be_q;
            sram_dout_en = 1'b1;
            next_state   = ACK;
         end
         ACK: begin
            ack        = gnt_q;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= '0;
         rdata   <= '0;
         gnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state <= next_state;
         if (state == RD || state == WR_PULSE)
            cnt <= last_beat ? '0 : cnt + CNT_W'(1);
         if (state == RD && last_beat)
            rdata <= sram_din;
         if (state == IDLE && win_valid) begin
            gnt_q   <= grant;
            addr_q  <= addr[win_idx*ADDR_W +: ADDR_W];
            wdata_q <= wdata[win_idx*DATA_W +: DATA_W];
            be_q    <= be[win_idx*BE_W +: BE_W];
`ifdef ROUND_ROBIN_EN
            ptr <= (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
`endif
         end
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected acks, a monitor pops and compares.
module tb_sram_arbiter;

   localparam int NP = 2, AW = 20, DW = 32, BW = 4, W = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic [NP-1:0]       req = '0, we = '0;
   logic [NP*AW-1:0]    addr = '0;
   logic [NP*DW-1:0]    wdata = '0;
   logic [NP*BW-1:0]    be = '0;
   logic [NP-1:0]       ack;
   logic [DW-1:0]       rdata, sram_dout, sram_din;
   logic [AW-1:0]       sram_addr;
   logic [BW-1:0]       sram_be_n;
   logic                sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en;

   typedef struct {
      int          port;
      int          cyc;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          n_chk_s = 0, n_pass_s = 0, n_chk_m = 0, n_pass_m = 0;
   logic [31:0] mem [0:255];
   bit          loaded = 1'b0;

   sram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .ack(ack), .rdata(rdata), .sram_addr(sram_addr), .sram_be_n(sram_be_n),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: byte-masked write while we_n is low, asynchronous read
   assign sram_din = mem[sram_addr[7:0]];
   always @(posedge clk) begin
      if (!loaded) begin
         for (int a = 0; a < 256; a++) mem[a] <= 32'h0;
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h20] <= 32'hAAAAAAAA;
         loaded     <= 1'b1;
      end else if (!sram_ce_n && !sram_we_n) begin
         for (int b = 0; b < BW; b++)
            if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_dout[8*b +: 8];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk_s++;
      if (act === exp) n_pass_s++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic mchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk_m++;
      if (act === exp) n_pass_m++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
         mchk("ack_timeout", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (ack != '0) begin
         if (sb.size() == 0) mchk("ack_unexpected", ack, 0);
         else begin
            mon_e = sb.pop_front();
            mchk("ack_port", ack, 1 << mon_e.port);
            mchk("ack_cycle", cyc, mon_e.cyc);
            mchk("ack_rdata", rdata, mon_e.rdata);
         end
      end
   end

   task automatic set_port(input int p, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] b);
      we[p]            = w;
      addr[p*AW +: AW] = a;
      wdata[p*DW +: DW] = d;
      be[p*BW +: BW]   = b;
      req[p]           = 1'b1;
   endtask

   task automatic push(input int p, input int c, input logic [31:0] r);
      exp_t e;
      e.port = p; e.cyc = c; e.rdata = r;
      sb.push_back(e);
   endtask

   initial begin
      int          c, lo, wl, p;
      logic [31:0] last_rd;
      bit          rr;
`ifdef ROUND_ROBIN_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ce_n", sram_ce_n, 1);
      chk("rst_oe_n", sram_oe_n, 1);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_be_n", sram_be_n, 4'hF);
      chk("rst_dout_en", sram_dout_en, 0);
      rst = 1'b1;
      @(negedge clk);

      // single read, port 1
      c = cyc; last_rd = 32'hDEADBEEF;
      set_port(1, 1'b0, 20'h00010, 32'h0, 4'hF);
      push(1, c + 1 + W, last_rd);
      lo = 0;
      for (int j = 1; j <= W + 1; j++) begin
         @(negedge clk);
         if (!sram_oe_n) lo++;
         if (j == 1) chk("rd_addr", sram_addr, 20'h00010);
         if (j <= W) chk("rd_ce_n", sram_ce_n, 0);
      end
      chk("rd_oe_low_cycles", lo, W);
      chk("rd_oe_n_in_ack", sram_oe_n, 1);
      req[1] = 1'b0;
      @(negedge clk);

      // write port 0, be 0011; rdata must keep the last read value
      c = cyc;
      set_port(0, 1'b1, 20'h00020, 32'h12345678, 4'b0011);
      push(0, c + 3 + W, last_rd);
      wl = 0;
      for (int j = 1; j <= W + 3; j++) begin
         @(negedge clk);
         if (!sram_we_n) wl++;
         if (j == 1) begin
            chk("wr_setup_we_n", sram_we_n, 1);
            chk("wr_be_n", sram_be_n, 4'b1100);
            chk("wr_setup_dout_en", sram_dout_en, 1);
            chk("wr_dout", sram_dout, 32'h12345678);
         end
         if (j == W + 2) begin
            chk("wr_hold_we_n", sram_we_n, 1);
            chk("wr_hold_dout_en", sram_dout_en, 1);
         end
         if (j == W + 3) begin
            chk("wr_ack_dout_en", sram_dout_en, 0);
            chk("wr_ack_be_n", sram_be_n, 4'hF);
         end
      end
      chk("wr_we_low_cycles", wl, W);
      req[0] = 1'b0;
      @(negedge clk);

      // write with no byte enables: full strobe, memory untouched
      c = cyc;
      set_port(0, 1'b1, 20'h00020, 32'hFFFFFFFF, 4'h0);
      push(0, c + 3 + W, last_rd);
      wl = 0;
      for (int j = 1; j <= W + 3; j++) begin
         @(negedge clk);
         if (!sram_we_n) wl++;
         if (j == 1) chk("be0_be_n", sram_be_n, 4'hF);
      end
      chk("be0_we_low_cycles", wl, W);
      req[0] = 1'b0;
      @(negedge clk);

      // read back merged word
      c = cyc; last_rd = 32'hAAAA5678;
      set_port(0, 1'b0, 20'h00020, 32'h0, 4'hF);
      push(0, c + 1 + W, last_rd);
      repeat (W + 1) @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);

      // fresh reset so the priority pointer starts at 0
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // both ports hold req for four back-to-back reads
      c = cyc;
      set_port(0, 1'b0, 20'h00010, 32'h0, 4'hF);
      set_port(1, 1'b0, 20'h00020, 32'h0, 4'hF);
      for (int n = 0; n < 4; n++) begin
         p = rr ? (n % 2) : 0;
         last_rd = (p == 1) ? 32'hAAAA5678 : 32'hDEADBEEF;
         push(p, c + 1 + W + n * (W + 2), last_rd);
      end
      repeat (W + 1 + 3 * (W + 2)) @(negedge clk);
      req = '0;
      @(negedge clk);

      // reset in the middle of the write pulse
      set_port(0, 1'b1, 20'h00030, 32'h55AA55AA, 4'hF);
      repeat (2) @(negedge clk);
      chk("pulse_we_n", sram_we_n, 0);
      rst = 1'b0;
      #1;
      chk("abort_we_n", sram_we_n, 1);
      chk("abort_dout_en", sram_dout_en, 0);
      chk("abort_ack", ack, 0);
      chk("abort_ce_n", sram_ce_n, 1);
      chk("abort_be_n", sram_be_n, 4'hF);
      chk("abort_rdata", rdata, 0);
      @(negedge clk);
      rst = 1'b1;
      c = cyc;
      push(0, c + 3 + W, 32'h0);
      repeat (W + 3) @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);

      // requester withdraws during RD: one ack, no retry
      c = cyc;
      set_port(1, 1'b0, 20'h00010, 32'h0, 4'hF);
      push(1, c + 1 + W, 32'hDEADBEEF);
      @(negedge clk);
      req[1] = 1'b0;
      repeat (8) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass_s + n_pass_m, n_chk_s + n_chk_m);
      $finish;
   end

endmodule
